// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_unit
//  Description : Direct-mapped BTB with 2-bit saturating counters. Supplies an
//                IF-stage next-PC prediction, resolves B/JAL/JALR outcomes in
//                EX, raises a redirect on mispredict, trains the table and
//                keeps branch / mispredict statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              ex_valid,
  input  logic [2:0]        ex_branch,
  input  logic              ex_bf,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_imm,
  input  logic [31:0]       ex_aluc,
  input  logic              ex_pred_taken,
  input  logic [31:0]       ex_pred_target,
  output logic              npc_op,
  output logic [31:0]       pc_jump,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] mis_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  // Table storage; tag/target/type are only meaningful while valid is set
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic             r_jump   [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_if_hit;
  logic             w_ex_hit;
  logic             w_at;
  logic [31:0]      w_tt;
  logic             w_is_b;
  logic             w_is_j;
  logic             w_mispredict;
  logic             unused_pc_bits;

  // Byte-offset bits of word-aligned PCs carry no information here
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == if_pc[31:IDX_W+2]);
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == ex_pc[31:IDX_W+2]);

  // IF lookup: asynchronous read, old contents seen on a same-cycle write
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = if_pc + 32'd4;
    if (!rst && w_if_hit && (r_jump[w_if_idx] || r_ctr[w_if_idx][1])) begin
      pred_taken  = 1'b1;
      pred_target = r_target[w_if_idx];
    end
  end

  // EX resolution: actual direction/target, priority B > JAL > JALR
  always_comb begin
    w_is_b = ex_branch[2];
    w_is_j = !ex_branch[2] && (ex_branch[1] || ex_branch[0]);
    w_at   = (ex_branch[2] && ex_bf) || ex_branch[1] || ex_branch[0];
    w_tt   = ex_pc + 32'd4;
    if (ex_branch[2] || ex_branch[1]) begin
      w_tt = ex_pc + ex_imm;
    end else if (ex_branch[0]) begin
      w_tt = ex_aluc;
    end
    w_mispredict = !rst && ex_valid &&
                   ((ex_pred_taken != w_at) || (w_at && (ex_pred_target != w_tt)));
    npc_op  = w_mispredict;
    pc_jump = (w_mispredict && w_at) ? w_tt : (ex_pc + 32'd4);
  end

  // Table training and statistics; reset dominates every write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (ex_valid) begin
      if (ex_branch != 3'b000) begin
        br_cnt <= br_cnt + STAT_W'(1);
      end
      if (w_mispredict) begin
        mis_cnt <= mis_cnt + STAT_W'(1);
      end
      if (w_is_b) begin
        if (w_ex_hit) begin
          if (w_at) begin
            r_target[w_ex_idx] <= w_tt;
            if (r_ctr[w_ex_idx] != 2'b11) begin
              r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'b01;
            end
          end else if (r_ctr[w_ex_idx] != 2'b00) begin
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'b01;
          end
        end else if (w_at) begin
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= ex_pc[31:IDX_W+2];
          r_target[w_ex_idx] <= w_tt;
          r_jump[w_ex_idx]   <= 1'b0;
          r_ctr[w_ex_idx]    <= 2'b10;
        end
      end else if (w_is_j) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= ex_pc[31:IDX_W+2];
        r_target[w_ex_idx] <= w_tt;
        r_jump[w_ex_idx]   <= 1'b1;
        r_ctr[w_ex_idx]    <= 2'b11;
      end else if (w_ex_hit) begin
        // A non-branch now lives at a PC the table believes is a branch
        r_valid[w_ex_idx] <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predict_unit
//  Description : Scoreboard bench for branch_predict_unit with a behavioural
//                table model, directed scenarios and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

  localparam int ENTRIES = 16;
  localparam int STAT_W  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [2:0]  ex_branch;
  logic        ex_bf;
  logic [31:0] ex_pc, ex_imm, ex_aluc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        npc_op;
  logic [31:0] pc_jump;
  logic [STAT_W-1:0] br_cnt, mis_cnt;

  branch_predict_unit #(.ENTRIES(ENTRIES), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_bf(ex_bf),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_aluc(ex_aluc),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .npc_op(npc_op), .pc_jump(pc_jump),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: one record per direct-mapped slot
  typedef struct {
    bit        v;
    bit [31:0] tagv;
    bit [31:0] tgt;
    bit        jmp;
    int        ctr;
  } ent_t;

  typedef struct {
    bit        pt;
    bit [31:0] ptg;
    bit        npc;
    bit [31:0] pj;
    bit [31:0] br;
    bit [31:0] mis;
  } exp_t;

  ent_t      m [ENTRIES];
  bit [31:0] m_br, m_mis;
  exp_t      expq [$];
  int        checks = 0;
  int        errors = 0;

  function automatic int slot(input bit [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit [31:0] tag_of(input bit [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit mhit(input bit [31:0] pc);
    return m[slot(pc)].v && (m[slot(pc)].tagv == tag_of(pc));
  endfunction

  function automatic void mlook(input bit [31:0] pc, output bit pt, output bit [31:0] tg);
    pt = mhit(pc) && (m[slot(pc)].jmp || m[slot(pc)].ctr >= 2);
    tg = pt ? m[slot(pc)].tgt : pc + 4;
  endfunction

  function automatic void mresolve(input bit [2:0] br, input bit bf, input bit [31:0] pc,
                                   input bit [31:0] imm, input bit [31:0] aluc,
                                   output bit at, output bit [31:0] tt);
    at = (br[2] && bf) || br[1] || br[0];
    if (br[2] || br[1]) tt = pc + imm;
    else if (br[0])     tt = aluc;
    else                tt = pc + 4;
  endfunction

  // Apply one cycle of inputs, queue the expected outputs, then advance the model
  task automatic drive(input bit r, input bit [31:0] ipc, input bit v, input bit [2:0] br,
                       input bit bf, input bit [31:0] pc, input bit [31:0] imm,
                       input bit [31:0] aluc, input bit ept, input bit [31:0] eptg);
    exp_t      e;
    bit        at, mp;
    bit [31:0] tt;
    int        s;
    rst = r; if_pc = ipc; ex_valid = v; ex_branch = br; ex_bf = bf;
    ex_pc = pc; ex_imm = imm; ex_aluc = aluc;
    ex_pred_taken = ept; ex_pred_target = eptg;
    mresolve(br, bf, pc, imm, aluc, at, tt);
    mp = !r && v && ((ept != at) || (at && eptg != tt));
    if (r) begin
      e.pt = 0; e.ptg = ipc + 4;
    end else begin
      mlook(ipc, e.pt, e.ptg);
    end
    e.npc = mp;
    e.pj  = (mp && at) ? tt : pc + 4;
    e.br  = m_br;
    e.mis = m_mis;
    expq.push_back(e);
    @(posedge clk);
    s = slot(pc);
    if (r) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m[i].v = 0; m[i].ctr = 1;
      end
      m_br = 0; m_mis = 0;
    end else if (v) begin
      if (br != 0) m_br = m_br + 1;
      if (mp) m_mis = m_mis + 1;
      if (br[2]) begin
        if (mhit(pc)) begin
          if (at) begin
            m[s].tgt = tt;
            m[s].ctr = (m[s].ctr == 3) ? 3 : m[s].ctr + 1;
          end else begin
            m[s].ctr = (m[s].ctr == 0) ? 0 : m[s].ctr - 1;
          end
        end else if (at) begin
          m[s].v = 1; m[s].tagv = tag_of(pc); m[s].tgt = tt; m[s].jmp = 0; m[s].ctr = 2;
        end
      end else if (br != 0) begin
        m[s].v = 1; m[s].tagv = tag_of(pc); m[s].tgt = tt; m[s].jmp = 1; m[s].ctr = 3;
      end else if (mhit(pc)) begin
        m[s].v = 0;
      end
    end
    #1;
  endtask

  task automatic chk(input string name, input bit [31:0] act, input bit [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("pred_taken",  32'(pred_taken),  32'(e.pt));
      chk("pred_target", pred_target,      e.ptg);
      chk("npc_op",      32'(npc_op),      32'(e.npc));
      chk("pc_jump",     pc_jump,          e.pj);
      chk("br_cnt",      br_cnt,           e.br);
      chk("mis_cnt",     mis_cnt,          e.mis);
    end
  end

  localparam bit [31:0] ALIAS = 32'h200 + 4 * ENTRIES;

  initial begin
    bit        ept, bf, r;
    bit [31:0] eptg, ipc, pc, imm, aluc;
    bit [2:0]  br;
    rst = 1; if_pc = 0; ex_valid = 0; ex_branch = 0; ex_bf = 0;
    ex_pc = 0; ex_imm = 0; ex_aluc = 0; ex_pred_taken = 0; ex_pred_target = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      m[i].v = 0; m[i].tagv = 0; m[i].tgt = 0; m[i].jmp = 0; m[i].ctr = 1;
    end
    m_br = 0; m_mis = 0;
    @(posedge clk); #1;

    // Reset
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    // Cold B-type taken, then lookup sees it
    drive(0, 32'h100, 1, 3'b100, 1, 32'h200, 32'h40, 0, 0, 0);
    drive(0, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
    // Hysteresis: taken, not-taken, taken mispredicted, three takens
    drive(0, 32'h200, 1, 3'b100, 1, 32'h200, 32'h40, 0, 1, 32'h240);
    drive(0, 32'h200, 1, 3'b100, 0, 32'h200, 32'h40, 0, 1, 32'h240);
    drive(0, 32'h200, 1, 3'b100, 0, 32'h200, 32'h40, 0, 1, 32'h240);
    drive(0, 32'h200, 1, 3'b100, 0, 32'h200, 32'h40, 0, 0, 0);
    drive(0, 32'h200, 1, 3'b100, 1, 32'h200, 32'h40, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      drive(0, 32'h200, 1, 3'b100, 1, 32'h200, 32'h40, 0, 1, 32'h240);
    drive(0, 32'h200, 1, 3'b100, 0, 32'h200, 32'h40, 0, 1, 32'h240);
    drive(0, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
    // JALR target change
    drive(0, 32'h300, 1, 3'b001, 0, 32'h300, 0, 32'h800, 0, 0);
    drive(0, 32'h300, 1, 3'b001, 0, 32'h300, 0, 32'h900, 1, 32'h800);
    drive(0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
    // Same-index read/write
    drive(0, 32'h200, 1, 3'b100, 0, 32'h200, 32'h40, 0, 1, 32'h240);
    drive(0, 32'h200, 1, 3'b100, 0, 32'h200, 32'h40, 0, 0, 0);
    drive(0, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
    // Aliasing, non-branch clearing, illegal multi-bit type
    drive(0, ALIAS, 1, 3'b010, 0, 32'h400, 32'h10, 0, 0, 0);
    drive(0, 32'h400, 1, 3'b000, 0, 32'h300, 0, 0, 0, 0);
    drive(0, 32'h300, 1, 3'b111, 0, 32'h500, 32'h20, 32'hABC, 0, 0);
    drive(0, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset during a mispredicting EX instruction
    drive(1, 32'h400, 1, 3'b010, 0, 32'h600, 32'h80, 0, 0, 0);
    drive(0, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic over a small PC pool that aliases heavily
    for (int n = 0; n < 600; n++) begin
      ipc  = 32'h200 + 4 * $urandom_range(0, 3 * ENTRIES - 1);
      pc   = 32'h200 + 4 * $urandom_range(0, 3 * ENTRIES - 1);
      case ($urandom_range(0, 9))
        0, 1:    br = 3'b000;
        2,3,4,5: br = 3'b100;
        6:       br = 3'b010;
        7, 8:    br = 3'b001;
        default: br = 3'($urandom_range(0, 7));
      endcase
      bf   = 1'($urandom_range(0, 1));
      imm  = 32'($urandom_range(0, 63) * 4) - 32'd128;
      aluc = 32'h1000 + 4 * $urandom_range(0, 7);
      r    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) != 0) begin
        mlook(pc, ept, eptg);
      end else begin
        ept  = 1'($urandom_range(0, 1));
        eptg = 32'h1000 + 4 * $urandom_range(0, 7);
      end
      drive(r, ipc, 1'($urandom_range(0, 4) != 0), br, bf, pc, imm, aluc, ept, eptg);
    end

    ex_valid = 0;
    for (int k = 0; k < 10 && expq.size() != 0; k++) @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predict_unit.md
# branch_predict_unit

Branch prediction and resolution unit for the five-stage pipeline, replacing the EX-stage-only jump decision. In IF it looks up a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and supplies a predicted next PC. In EX it resolves the real outcome for B-type, JAL and JALR instructions. On a misprediction it raises a redirect (`npc_op`/`pc_jump`) and trains the table. It also keeps branch and mispredict statistics counters.

## Interface
- `ENTRIES`, 16, number of BTB entries; must be a power of two, ≥2. `IDX_W = log2(ENTRIES)`.
- `STAT_W`, 32, width of the statistics counters.

- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_pc`  in  32  PC of the instruction in IF
- `pred_taken`  out  1  IF prediction: redirect fetch
- `pred_target`  out  32  IF predicted next PC
- `ex_valid`  in  1  EX holds a real (non-bubble) instruction
- `ex_branch`  in  3  [2]=B-type, [1]=JAL, [0]=JALR; priority [2]>[1]>[0]
- `ex_bf`  in  1  B-type condition true (from ALU)
- `ex_pc`  in  32  PC of the EX instruction
- `ex_imm`  in  32  immediate of the EX instruction
- `ex_aluc`  in  32  ALU result (JALR target)
- `ex_pred_taken`  in  1  `pred_taken` carried down with this instruction
- `ex_pred_target`  in  32  `pred_target` carried down with this instruction
- `npc_op`  out  1  EX redirect request; flush IF/ID
- `pc_jump`  out  32  redirect PC, valid when `npc_op`=1
- `br_cnt`  out  STAT_W  resolved control-flow instructions
- `mis_cnt`  out  STAT_W  mispredictions

## Operation
- **Entry contents:** valid, tag = `pc[31:IDX_W+2]`, target[31:0], type (B / JUMP), ctr[1:0].
- **Index:** `pc[IDX_W+1:2]`.
- **Lookup (IF, combinational):**
  - A hit means the entry at `if_pc` is valid and its tag matches.
  - `pred_taken` = hit & (type==JUMP | ctr[1]).
  - `pred_target` = stored target when `pred_taken`, else `if_pc+4`.
- **Resolution (EX, combinational):**
  - Actual taken `at` = (`ex_branch[2]` & `ex_bf`) | `ex_branch[1]` | `ex_branch[0]`.
  - Actual target `tt`: if [2] then `ex_pc+ex_imm`; else if [1] then `ex_pc+ex_imm`; else if [0] then `ex_aluc`.
  - `mispredict` = `ex_valid` & ((`ex_pred_taken`≠`at`) | (`at` & `ex_pred_target`≠`tt`)).
  - `npc_op` = `mispredict`.
  - `pc_jump` = `at` ? `tt` : `ex_pc+4`. When `npc_op`=0, `pc_jump` = `ex_pc+4`.
- **Training (clock edge, only when `ex_valid`):**
  - **B-type, hit:** ctr saturating +1 if taken, −1 if not. Saturates at 3 and 0. Target is rewritten with `tt` when taken.
  - **B-type, miss, taken:** allocate or overwrite the entry. Set valid=1, tag, target=`tt`, type=B, ctr=2'b10.
  - **B-type, miss, not taken:** no write.
  - **JAL/JALR:** allocate or overwrite with type=JUMP, ctr=2'b11, target=`tt` (JALR always retrains its target).
  - **`ex_branch`==0 on a hit entry:** clear valid (alias/self-modifying guard). On a miss: no write.
- **Statistics:**
  - `br_cnt` +1 when `ex_valid` & `ex_branch`≠0.
  - `mis_cnt` +1 on `mispredict`.
  - Both wrap modulo 2^STAT_W.

## Timing
- Lookup has zero latency: the table is read asynchronously and the prediction is available in the same cycle as `if_pc`.
- Redirect has zero latency: `npc_op`/`pc_jump` are combinational from the EX inputs. The pipeline flushes the two younger stages on the next edge.
- A training write lands on the rising edge of the EX cycle and is visible to lookups from the next cycle on.
- **Same-cycle read/write:** when IF and EX address the same index, IF sees the old entry. There is no bypass.
- **Reset (`rst`=1 at an edge):**
  - All valid bits cleared and all ctr set to 2'b01.
  - `br_cnt`=`mis_cnt`=0.
- **While `rst`=1 (combinational outputs forced):**
  - `pred_taken`=0, `pred_target`=`if_pc+4`.
  - `npc_op`=0, `pc_jump`=`ex_pc+4`.
  - No training and no counting.
- **Reset mid-operation:** an in-flight EX instruction is dropped with no training. Reset has priority over every write.
- **Illegal `ex_branch` with multiple bits set:** resolved by priority [2]>[1]>[0] for both target and type.

## Test plan
- **Reset:** assert `rst` 2 cycles, then read `if_pc`=0x100 → `pred_taken`=0, `pred_target`=0x104, `br_cnt`=`mis_cnt`=0, `npc_op`=0.
- **Cold B-type taken:** `ex_pc`=0x200, imm=0x40, bf=1, `ex_pred_taken`=0 → `npc_op`=1, `pc_jump`=0x240, `mis_cnt`=1. Next cycle `if_pc`=0x200 → `pred_taken`=1, `pred_target`=0x240.
- **Counter hysteresis:** loop at 0x200 resolves taken, then not-taken once (`npc_op`=1, `pc_jump`=0x204, ctr 2→1). Then taken with `ex_pred_taken`=0 → mispredict again. Check `mis_cnt` increments each time and ctr saturates at 3 after three further takens.
- **JALR target change:** JALR at 0x300 with `ex_aluc`=0x800, then again with `ex_aluc`=0x900 while carrying `ex_pred_target`=0x800 → second resolve gives `npc_op`=1, `pc_jump`=0x900, and the entry retrains to 0x900.
- **Same-index read/write:** EX trains 0x200 while `if_pc`=0x200 in the same cycle → IF shows the pre-write prediction. The next cycle shows the updated one.
- **Aliasing and reset during activity:** `if_pc`=0x200+4·ENTRIES (same index, different tag) → `pred_taken`=0. A non-branch resolved at a hit PC clears that entry. Asserting `rst` while `ex_valid`=1 with a mispredict → `npc_op`=0, and no counter or table change is visible after reset.
